instruction_prefetch: RTL and testbench
=======================================

Name: instruction_prefetch

Overview:
- Sits between the combinational program ROM (16-bit addr in, 16-bit data out, same-cycle) and the CPU execute stage.
- Owns the fetch program counter and drives the ROM address.
- Buffers fetched words in a small FIFO and hands them to the CPU over a valid/ready handshake.
- Supports a one-cycle redirect for jump, branch, call and return, which flushes all buffered words.

Parameters:
- DEPTH, 2, FIFO entries (power of two, 2..8).
- RESET_ADDR, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  16  address to program ROM.
- rom_data  in  16  ROM word for rom_addr, valid in the same cycle.
- instr_data  out  16  head-of-FIFO instruction word.
- instr_addr  out  16  ROM address that instr_data came from.
- instr_valid  out  1  FIFO non-empty and no redirect pending.
- instr_ready  in  1  CPU consumes head word when valid && ready.
- redirect  in  1  one-cycle pulse: discard buffer, resume at redirect_addr.
- redirect_addr  in  16  new fetch address, sampled when redirect=1.
- fifo_count  out  log2(DEPTH)+1  occupancy, for debug and LED display.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on the rising edge of clk.
- Reset values (next edge with reset=1):
  - pc = RESET_ADDR, so rom_addr = RESET_ADDR.
  - FIFO empty, fifo_count = 0, instr_valid = 0.
  - instr_data and instr_addr = 16'h0000.
- Reset dominates redirect and all handshakes. Reset asserted mid-stream discards everything; no partial state survives.
- rom_addr = pc combinationally. Each cycle, push {pc, rom_data} and increment pc iff push_en.
- push_en = !redirect && (count < DEPTH || pop). Pushing while full is allowed only with a simultaneous pop.
- pop = instr_valid && instr_ready.
- pc arithmetic is 16-bit and wraps modulo 2^16: 16'hffff fetches, then pc becomes 16'h0000. No error flag.
- Latency:
  - ROM word fetched in cycle N is visible on instr_data/instr_valid in cycle N+1.
  - Steady-state throughput with instr_ready held high is 1 word/cycle.
- instr_data and instr_addr are driven from the FIFO head register, never combinationally from rom_data.
- When instr_valid=0, instr_data and instr_addr hold their last values. The bench must not check them.
- FIFO is a circular buffer with wr_ptr, rd_ptr and count:
  - Full (count == DEPTH): no push unless pop in the same cycle. pc holds.
  - Empty: instr_valid = 0. The CPU's ready is ignored.
- Redirect (redirect=1 in cycle N):
  - Next edge: FIFO flushed (count = 0, pointers = 0) and pc = redirect_addr.
  - No push in cycle N; the word at the old pc is dropped.
  - If a pop also occurs in cycle N, that head word counts as consumed, and the flush removes the rest.
  - Cycle N+1: rom_addr = redirect_addr, instr_valid = 0.
  - Cycle N+2: first word from redirect_addr presented. Redirect penalty is 2 cycles.
  - Back-to-back redirects: the last one wins. Each one flushes again.
- No redirect_addr range checking. The ROM returns 16'hxxxx beyond the program, and this block passes it through unmodified.
- fifo_count reflects the registered count.

Decomposition:
- Shared package fetch_pkg holds:
  - the 16-bit word and address width constants;
  - RESET_ADDR default;
  - a packed struct fetch_entry_t {addr[15:0], data[15:0]}.
- One sub-module, fetch_fifo: a generic DEPTH-entry synchronous FIFO with push, pop, flush, count, full and empty.
- The top level keeps only the pc register, the push/pop/redirect logic and the output muxing.

Test Plan:
- Reset, then instr_ready=1 with the ROM model loaded with the current application image:
  - instr_addr sequence is 0x00,0x01,0x02 on consecutive cycles from cycle 1;
  - instr_data is 16'h2201, 16'h0a00, 16'h0210.
- Backpressure: hold instr_ready=0 for 5 cycles after reset.
  - fifo_count saturates at 2 and rom_addr holds at 0x02.
  - On release, words for 0x00, 0x01, 0x02 emerge in order with none lost or duplicated.
- Redirect: pulse redirect with redirect_addr=16'h002b while the head is at 0x07.
  - instr_valid is low for exactly 1 cycle after the pulse cycle.
  - Next presented word is addr 0x2b, data 16'h03a0, then 0x2c/16'h30d4.
- Simultaneous pop+redirect with FIFO full:
  - the popped word is consumed exactly once;
  - the other buffered word never appears;
  - the next valid word comes from redirect_addr=16'h0006.
- Wrap: redirect_addr=16'hfffe with instr_ready=1. instr_addr runs 0xfffe, 0xffff, 0x0000, 0x0001.
- Reset mid-stream: assert reset for 1 cycle while fifo_count=2 and a redirect is pending.
  - Next cycle: fifo_count=0, instr_valid=0, rom_addr=RESET_ADDR.
  - The redirect is ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch unit.
//   - ADDR_W / DATA_W     : program ROM address and word widths
//   - DEFAULT_RESET_ADDR  : default first fetch address after reset
//   - fetch_entry_t       : one buffered fetch, {addr, data}
//   - next_pc()           : sequential fetch address, wraps modulo 2^16
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_ADDR = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;

  // 16-bit arithmetic: 16'hffff is followed by 16'h0000, with no error flag.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous circular-buffer FIFO.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears storage too)
//   flush       : empties the FIFO and zeroes both pointers; storage is kept
//   push, push_data : write an entry; accepted when not full, or when full
//                     with a simultaneous pop
//   pop         : remove the head entry; ignored when empty
//   head        : registered head entry (mem[rd_ptr])
//   count       : occupancy 0..DEPTH
//   full, empty : occupancy flags
// DEPTH must be a power of two (2..8) so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  // Writing into a full buffer is safe only because the head slot is freed
  // in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Flush dominates any push or pop in the same cycle.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetch unit between a same-cycle combinational program ROM
// and the CPU execute stage.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   rom_addr        : fetch address to the ROM (equals the fetch pc)
//   rom_data        : ROM word for rom_addr, valid in the same cycle
//   instr_data      : head-of-buffer instruction word
//   instr_addr      : ROM address instr_data was fetched from
//   instr_valid     : buffer holds at least one word
//   instr_ready     : CPU accepts the head word
//   redirect        : one-cycle pulse, discard buffer and refetch
//   redirect_addr   : new fetch address, sampled with redirect
//   fifo_count      : registered buffer occupancy (debug / LED display)
//
// Handshake: a word transfers to the CPU on a rising edge where
// instr_valid && instr_ready are both high. instr_valid never depends on
// instr_ready, and instr_ready is ignored while instr_valid is low. While
// instr_valid is low, instr_data/instr_addr hold stale values.
module instruction_prefetch
  import fetch_pkg::*;
#(
  parameter int                DEPTH      = 2,
  parameter logic [ADDR_W-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic [DATA_W-1:0]      instr_data,
  output logic [ADDR_W-1:0]      instr_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic [ADDR_W-1:0] pc;
  logic              pop;
  logic              push_en;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  assign rom_addr    = pc;
  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;

  // The word at the old pc is dropped on a redirect; otherwise fetch whenever
  // there is (or will be, thanks to a pop) room in the buffer.
  assign push_en = !redirect && (!fifo_full || pop);

  assign push_entry.addr = pc;
  assign push_entry.data = rom_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_ADDR;
    end else if (redirect) begin
      pc <= redirect_addr;
    end else if (push_en) begin
      pc <= next_pc(pc);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs come from the registered head entry, never from rom_data.
  assign instr_data = head_entry.data;
  assign instr_addr = head_entry.addr;

endmodule

// File: tb/tb_instruction_prefetch.sv
module tb_instruction_prefetch;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   rom_addr;
  logic [15:0]   rom_data;
  logic [15:0]   instr_data;
  logic [15:0]   instr_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [15:0]   redirect_addr;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  instruction_prefetch #(
    .DEPTH      (DEPTH),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .instr_data    (instr_data),
    .instr_addr    (instr_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .fifo_count    (fifo_count)
  );

  // Combinational ROM: random image with the application words placed in it.
  logic [15:0] rom_mem [65536];
  assign rom_data = rom_mem[rom_addr];

  // ------------------------------------------------------- reference model
  // Expected buffer contents as {addr, data}, front = word on instr_data.
  logic [31:0] exp_q [$];
  logic [15:0] m_pc;
  logic [15:0] cons_q [$];   // addresses consumed by the CPU, in order
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the fetch rules: pop if a word is held and the CPU is ready;
  // redirect discards everything and moves the fetch pointer; otherwise a
  // word is fetched when there is room (counting the slot a pop frees).
  task automatic model_update(input logic r, input logic rdy, input logic rd,
                              input logic [15:0] ra);
    int  held;
    logic popped;
    logic [31:0] w;
    if (r) begin
      exp_q.delete();
      m_pc = 16'h0000;
      return;
    end
    held   = exp_q.size();
    popped = (held > 0) && rdy;
    if (popped) begin
      w = exp_q.pop_front();
      cons_q.push_back(w[31:16]);
    end
    if (rd) begin
      exp_q.delete();
      m_pc = ra;
    end else if (held < DEPTH || popped) begin
      exp_q.push_back({m_pc, rom_mem[m_pc]});
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic check_state();
    logic [31:0] head;
    chk("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("instr_addr", 32'(instr_addr), 32'(head[31:16]));
      chk("instr_data", 32'(instr_data), 32'(head[15:0]));
    end
  endtask

  // ------------------------------------------------------------ driver task
  task automatic step(input logic r, input logic rdy, input logic rd,
                      input logic [15:0] ra);
    reset         = r;
    instr_ready   = rdy;
    redirect      = rd;
    redirect_addr = ra;
    @(posedge clk);
    model_update(r, rdy, rd, ra);
    @(negedge clk);
    check_state();
  endtask

  // Watchdog: the sequence is fixed-length, but never let the run hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    logic [15:0] wrap_exp [4];
    logic [15:0] app_addr [5];
    logic [15:0] app_data [5];
    wrap_exp = '{16'hfffe, 16'hffff, 16'h0000, 16'h0001};
    app_addr = '{16'h0000, 16'h0001, 16'h0002, 16'h002b, 16'h002c};
    app_data = '{16'h2201, 16'h0a00, 16'h0210, 16'h03a0, 16'h30d4};

    for (int i = 0; i < 65536; i++) rom_mem[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) rom_mem[app_addr[i]] = app_data[i];

    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    m_pc = 16'h0000;

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0000);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_instr_data", 32'(instr_data), 32'h0000);
    chk("rst_instr_addr", 32'(instr_addr), 32'h0000);

    // Streaming with the CPU always ready.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      chk("stream_addr", 32'(instr_addr), 32'(app_addr[i]));
      chk("stream_data", 32'(instr_data), 32'(app_data[i]));
    end

    // Backpressure: 5 cycles not ready after reset, then drain.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("bp_count_sat", 32'(fifo_count), 32'd2);
    chk("bp_rom_addr", 32'(rom_addr), 32'h0002);
    cons_q.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("bp_drain_n", 32'(cons_q.size()), 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_order", 32'(cons_q[i]), 32'(app_addr[i]));
    end

    // Redirect while the head is at 0x07.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("pre_redir_head", 32'(instr_addr), 32'h0007);
    step(1'b0, 1'b1, 1'b1, 16'h002b);
    chk("redir_bubble", 32'(instr_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("redir_valid", 32'(instr_valid), 32'h1);
    chk("redir_addr0", 32'(instr_addr), 32'h002b);
    chk("redir_data0", 32'(instr_data), 32'h03a0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("redir_addr1", 32'(instr_addr), 32'h002c);
    chk("redir_data1", 32'(instr_data), 32'h30d4);

    // Pop + redirect together while full.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("pr_full", 32'(fifo_count), 32'd2);
    cons_q.delete();
    step(1'b0, 1'b1, 1'b1, 16'h0006);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("pr_cons_n", 32'(cons_q.size()), 32'd3);
    chk("pr_cons0", 32'(cons_q[0]), 32'h0000);
    chk("pr_cons1", 32'(cons_q[1]), 32'h0006);
    chk("pr_cons2", 32'(cons_q[2]), 32'h0007);

    // Wrap around the top of the address space.
    step(1'b0, 1'b1, 1'b1, 16'hfffe);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 16'h0);
      chk("wrap_addr", 32'(instr_addr), 32'(wrap_exp[i]));
    end

    // Reset mid-stream with a full buffer and a redirect at the same edge.
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("mid_full", 32'(fifo_count), 32'd2);
    step(1'b1, 1'b1, 1'b1, 16'h4321);
    chk("mid_count", 32'(fifo_count), 32'd0);
    chk("mid_valid", 32'(instr_valid), 32'h0);
    chk("mid_rom_addr", 32'(rom_addr), 32'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("mid_first_addr", 32'(instr_addr), 32'h0000);

    // Randomized traffic: ready, redirects (some near the wrap point), resets.
    for (int i = 0; i < 600; i++) begin
      logic r, rdy, rd;
      logic [15:0] ra;
      r   = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      ra  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                        : 16'(16'hfffc + $urandom_range(0, 3));
      step(r, rdy, rd, ra);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
